// File: rtl/cv32e40p_rf_wb_buffer.sv
// rtl/cv32e40p_rf_wb_buffer.sv - write-back buffer and pending-register scoreboard for RF write port B
// Optional same-cycle bypass of an empty FIFO: CV32E40P_WB_BYPASS_EN
module cv32e40p_rf_wb_buffer #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     issue_valid_i,
    input  logic [ADDR_WIDTH-1:0]    issue_waddr_i,
    output logic                     issue_ready_o,
    input  logic                     rsp_valid_i,
    input  logic [ADDR_WIDTH-1:0]    rsp_waddr_i,
    input  logic [DATA_WIDTH-1:0]    rsp_wdata_i,
    output logic                     rsp_ready_o,
    output logic [ADDR_WIDTH-1:0]    waddr_b_o,
    output logic [DATA_WIDTH-1:0]    wdata_b_o,
    output logic                     we_b_o,
    input  logic [ADDR_WIDTH-1:0]    raddr_a_i,
    input  logic [ADDR_WIDTH-1:0]    raddr_b_i,
    input  logic [ADDR_WIDTH-1:0]    raddr_c_i,
    input  logic [2:0]               ren_i,
    input  logic [ADDR_WIDTH-1:0]    waddr_a_i,
    input  logic                     we_a_i,
    output logic                     hazard_o,
    output logic [2**ADDR_WIDTH-1:0] pending_o,
    output logic                     err_o
);

    localparam int NREG = 2**ADDR_WIDTH;
    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;

    logic [NREG-1:0]       pending_q, pending_d;
    logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [PW-1:0]         head_q, tail_q;
    logic [CW-1:0]         count_q;
    logic                  err_q;
    logic                  fifo_empty;
    logic                  rsp_accept;
    logic                  push;
    logic                  pop;
    logic                  bypass;
    logic                  issue_set;

    assign fifo_empty  = (count_q == '0);
    assign rsp_ready_o = (count_q < CW'(DEPTH));
    assign rsp_accept  = rsp_valid_i & rsp_ready_o;

`ifdef CV32E40P_WB_BYPASS_EN
    // Gated by rst_n so a response presented during reset never reaches port B.
    assign bypass = rsp_accept & fifo_empty & rst_n;
`else
    assign bypass = 1'b0;
`endif

    assign push   = rsp_accept & ~bypass;
    assign pop    = ~fifo_empty;
    assign we_b_o = pop | bypass;

    always_comb begin
        waddr_b_o = '0;
        wdata_b_o = '0;
        if (pop) begin
            waddr_b_o = addr_mem[head_q];
            wdata_b_o = data_mem[head_q];
        end
`ifdef CV32E40P_WB_BYPASS_EN
        else if (bypass) begin
            waddr_b_o = rsp_waddr_i;
            wdata_b_o = rsp_wdata_i;
        end
`endif
    end

    assign issue_ready_o = ~pending_q[issue_waddr_i];
    assign issue_set     = issue_valid_i & issue_ready_o & (issue_waddr_i != '0);

    // Clear is taken when the entry is actually written, so a pending read stalls until the RF holds the value.
    always_comb begin
        pending_d = pending_q;
        if (issue_set) begin
            pending_d[issue_waddr_i] = 1'b1;
        end
        if (we_b_o) begin
            pending_d[waddr_b_o] = 1'b0;
        end
        pending_d[0] = 1'b0;
    end

    assign hazard_o = (ren_i[0] & pending_q[raddr_a_i])
                    | (ren_i[1] & pending_q[raddr_b_i])
                    | (ren_i[2] & pending_q[raddr_c_i])
                    | (we_a_i   & pending_q[waddr_a_i]);

    assign pending_o = pending_q;
    assign err_o     = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            head_q    <= head_q + PW'(pop);
            tail_q    <= tail_q + PW'(push);
            count_q   <= count_q + CW'(push) - CW'(pop);
            if (rsp_accept && (rsp_waddr_i != '0) && !pending_q[rsp_waddr_i]) begin
                err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail_q] <= rsp_waddr_i;
            data_mem[tail_q] <= rsp_wdata_i;
        end
    end

endmodule

// File: tb/tb_cv32e40p_rf_wb_buffer.sv
// tb/tb_cv32e40p_rf_wb_buffer.sv - self-checking bench for cv32e40p_rf_wb_buffer
module tb_cv32e40p_rf_wb_buffer;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 2;
`ifdef CV32E40P_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          issue_valid = 1'b0;
    logic [AW-1:0] issue_waddr = '0;
    logic          issue_ready;
    logic          rsp_valid = 1'b0;
    logic [AW-1:0] rsp_waddr = '0;
    logic [DW-1:0] rsp_wdata = '0;
    logic          rsp_ready;
    logic [AW-1:0] waddr_b;
    logic [DW-1:0] wdata_b;
    logic          we_b;
    logic [AW-1:0] raddr_a = '0, raddr_b = '0, raddr_c = '0;
    logic [2:0]    ren = '0;
    logic [AW-1:0] waddr_a = '0;
    logic          we_a = 1'b0;
    logic          hazard;
    logic [31:0]   pending;
    logic          err;

    cv32e40p_rf_wb_buffer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid_i(issue_valid), .issue_waddr_i(issue_waddr), .issue_ready_o(issue_ready),
        .rsp_valid_i(rsp_valid), .rsp_waddr_i(rsp_waddr), .rsp_wdata_i(rsp_wdata), .rsp_ready_o(rsp_ready),
        .waddr_b_o(waddr_b), .wdata_b_o(wdata_b), .we_b_o(we_b),
        .raddr_a_i(raddr_a), .raddr_b_i(raddr_b), .raddr_c_i(raddr_c), .ren_i(ren),
        .waddr_a_i(waddr_a), .we_a_i(we_a),
        .hazard_o(hazard), .pending_o(pending), .err_o(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t     mq[$];
    bit       pend[32];
    bit       m_err;
    int       checks = 0;
    int       errors = 0;

    logic          exp_we, exp_rsp_ready, exp_issue_ready, exp_hazard, exp_err;
    logic [AW-1:0] exp_waddr;
    logic [DW-1:0] exp_wdata;
    logic [31:0]   exp_pending;

    task automatic model_reset;
        mq.delete();
        foreach (pend[i]) pend[i] = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic model_expect;
        bit byp;
        exp_rsp_ready = (mq.size() < DEPTH);
        byp = BYP && rsp_valid && (mq.size() == 0);
        exp_we = (mq.size() > 0) || byp;
        exp_waddr = '0;
        exp_wdata = '0;
        if (mq.size() > 0) begin
            exp_waddr = mq[0].a;
            exp_wdata = mq[0].d;
        end else if (byp) begin
            exp_waddr = rsp_waddr;
            exp_wdata = rsp_wdata;
        end
        exp_issue_ready = !pend[issue_waddr];
        exp_hazard = (ren[0] && pend[raddr_a]) || (ren[1] && pend[raddr_b])
                  || (ren[2] && pend[raddr_c]) || (we_a && pend[waddr_a]);
        for (int i = 0; i < 32; i++) exp_pending[i] = pend[i];
        exp_err = m_err;
    endtask

    // Advance one clock, applying the spec's rules to the queue/array model with the inputs of this cycle.
    task automatic model_step;
        bit   push, byp, set;
        ent_t e;
        push = rsp_valid && (mq.size() < DEPTH);
        byp  = BYP && push && (mq.size() == 0);
        set  = issue_valid && !pend[issue_waddr] && (issue_waddr != 0);
        if (push && rsp_waddr != 0 && !pend[rsp_waddr]) m_err = 1'b1;
        if (mq.size() > 0) begin
            e = mq.pop_front();
            pend[e.a] = 1'b0;
        end else if (byp) begin
            pend[rsp_waddr] = 1'b0;
        end
        if (push && !byp) begin
            e.a = rsp_waddr;
            e.d = rsp_wdata;
            mq.push_back(e);
        end
        if (set) pend[issue_waddr] = 1'b1;
        pend[0] = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        issue_valid = 1'b0; rsp_valid = 1'b0; ren = '0; we_a = 1'b0;
        issue_waddr = '0; rsp_waddr = '0; rsp_wdata = '0;
        raddr_a = '0; raddr_b = '0; raddr_c = '0; waddr_a = '0;
    endtask

    task automatic test_reset;
        idle_inputs();
        ren = 3'b111; we_a = 1'b1; raddr_a = 5'd3; waddr_a = 5'd9;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        checks++; if (we_b !== 1'b0) begin errors++; $display("FAIL reset_we act=%0h exp=0", we_b); end
        checks++; if (waddr_b !== '0) begin errors++; $display("FAIL reset_waddr act=%0h exp=0", waddr_b); end
        checks++; if (wdata_b !== '0) begin errors++; $display("FAIL reset_wdata act=%0h exp=0", wdata_b); end
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL reset_hazard act=%0h exp=0", hazard); end
        checks++; if (pending !== '0) begin errors++; $display("FAIL reset_pending act=%0h exp=0", pending); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err act=%0h exp=0", err); end
        checks++; if (rsp_ready !== 1'b1) begin errors++; $display("FAIL reset_rsp_ready act=%0h exp=1", rsp_ready); end
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_issue_ready act=%0h exp=1", issue_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_inputs();
    endtask

    task automatic test_basic;
        issue_valid = 1'b1; issue_waddr = 5'd5;
        @(negedge clk);
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL basic_issue_ready act=%0h exp=1", issue_ready); end
        model_step();
        issue_valid = 1'b0; ren = 3'b001; raddr_a = 5'd5;
        @(negedge clk);
        checks++; if (pending[5] !== 1'b1) begin errors++; $display("FAIL basic_pending_set act=%0h exp=1", pending[5]); end
        checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL basic_hazard act=%0h exp=1", hazard); end
        model_step();
        rsp_valid = 1'b1; rsp_waddr = 5'd5; rsp_wdata = 32'hDEADBEEF;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            model_expect();
            checks++; if (we_b !== exp_we) begin errors++; $display("FAIL basic_we c=%0d act=%0h exp=%0h", c, we_b, exp_we); end
            if (exp_we) begin
                checks++; if (waddr_b !== 5'd5 || wdata_b !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_wb c=%0d act=%0h/%0h exp=5/deadbeef", c, waddr_b, wdata_b); end
            end
            checks++; if (pending !== exp_pending) begin errors++; $display("FAIL basic_pending c=%0d act=%0h exp=%0h", c, pending, exp_pending); end
            model_step();
            rsp_valid = 1'b0;
        end
        checks++; if (pending[5] !== 1'b0) begin errors++; $display("FAIL basic_pending_clear act=%0h exp=0", pending[5]); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL basic_err act=%0h exp=0", err); end
        idle_inputs();
    endtask

    task automatic test_hazard(input logic [AW-1:0] ra);
        issue_valid = 1'b1; issue_waddr = 5'd7;
        model_step();
        issue_valid = 1'b0; ren = 3'b001; raddr_a = ra;
        for (int c = 0; c < 6; c++) begin
            rsp_valid = (c == 1); rsp_waddr = 5'd7; rsp_wdata = $urandom;
            @(negedge clk);
            model_expect();
            checks++; if (hazard !== exp_hazard) begin errors++; $display("FAIL hazard ra=%0d c=%0d act=%0h exp=%0h", ra, c, hazard, exp_hazard); end
            if (ra == 0) begin
                checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL hazard_x0 c=%0d act=%0h exp=0", c, hazard); end
            end
            model_step();
        end
        idle_inputs();
    endtask

    task automatic test_reissue;
        logic [31:0] snap;
        issue_valid = 1'b1; issue_waddr = 5'd3;
        model_step();
        @(negedge clk);
        snap = pending;
        checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL reissue_ready act=%0h exp=0", issue_ready); end
        model_step();
        issue_valid = 1'b0;
        @(negedge clk);
        checks++; if (pending !== snap || snap[3] !== 1'b1) begin errors++; $display("FAIL reissue_sb act=%0h exp=%0h", pending, snap); end
        rsp_valid = 1'b1; rsp_waddr = 5'd3; rsp_wdata = $urandom;
        model_step();
        rsp_valid = 1'b0;
        model_step();
        model_step();
        issue_waddr = 5'd3;
        @(negedge clk);
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reissue_after act=%0h exp=1", issue_ready); end
        idle_inputs();
    endtask

    task automatic test_back_to_back;
        int seen[$];
        for (int r = 1; r <= 3; r++) begin
            issue_valid = 1'b1; issue_waddr = AW'(r);
            model_step();
        end
        issue_valid = 1'b0;
        for (int c = 0; c < 7; c++) begin
            rsp_valid = (c < 3);
            rsp_waddr = AW'(c + 1);
            rsp_wdata = $urandom;
            @(negedge clk);
            model_expect();
            if (c < 3) begin
                checks++; if (rsp_ready !== 1'b1) begin errors++; $display("FAIL b2b_rsp_ready c=%0d act=%0h exp=1", c, rsp_ready); end
            end
            checks++; if (we_b !== exp_we) begin errors++; $display("FAIL b2b_we c=%0d act=%0h exp=%0h", c, we_b, exp_we); end
            if (exp_we) begin
                checks++; if (waddr_b !== exp_waddr || wdata_b !== exp_wdata) begin errors++; $display("FAIL b2b_wb c=%0d act=%0h/%0h exp=%0h/%0h", c, waddr_b, wdata_b, exp_waddr, exp_wdata); end
            end
            if (we_b === 1'b1) seen.push_back(int'(waddr_b));
            model_step();
        end
        checks++; if (seen.size() != 3 || seen[0] != 1 || seen[1] != 2 || seen[2] != 3) begin errors++; $display("FAIL b2b_order act=%p exp=1,2,3", seen); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL b2b_err act=%0h exp=0", err); end
        idle_inputs();
    endtask

    task automatic test_error;
        bit wrote9;
        wrote9 = 1'b0;
        rsp_valid = 1'b1; rsp_waddr = 5'd9; rsp_wdata = 32'h0000_0909;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (we_b === 1'b1 && waddr_b === 5'd9 && wdata_b === 32'h0000_0909) wrote9 = 1'b1;
            if (c > 0) begin
                checks++; if (err !== 1'b1) begin errors++; $display("FAIL error_sticky c=%0d act=%0h exp=1", c, err); end
            end
            model_step();
            rsp_valid = 1'b0;
        end
        checks++; if (!wrote9) begin errors++; $display("FAIL error_write act=0 exp=1"); end
        idle_inputs();
    endtask

    task automatic test_mid_reset;
        issue_valid = 1'b1; issue_waddr = 5'd4;
        model_step();
        issue_valid = 1'b0;
        rsp_valid = 1'b1; rsp_waddr = 5'd4; rsp_wdata = 32'h4444_0004;
        model_step();
        rsp_valid = 1'b0;
        model_expect();
        checks++; if (we_b !== exp_we) begin errors++; $display("FAIL midrst_pre_we act=%0h exp=%0h", we_b, exp_we); end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++; if (we_b !== 1'b0) begin errors++; $display("FAIL midrst_we act=%0h exp=0", we_b); end
        checks++; if (pending !== '0) begin errors++; $display("FAIL midrst_pending act=%0h exp=0", pending); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL midrst_err act=%0h exp=0", err); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (rsp_ready !== 1'b1 || we_b !== 1'b0) begin errors++; $display("FAIL midrst_after act=%0h/%0h exp=1/0", rsp_ready, we_b); end
        idle_inputs();
        model_step();
    endtask

    task automatic test_random;
        for (int c = 0; c < 400; c++) begin
            issue_valid = ($urandom_range(0, 2) == 0);
            issue_waddr = AW'($urandom_range(0, 31));
            rsp_valid = ($urandom_range(0, 1) == 0);
            rsp_waddr = AW'($urandom_range(0, 31));
            rsp_wdata = $urandom;
            ren = 3'($urandom_range(0, 7));
            raddr_a = AW'($urandom_range(0, 31));
            raddr_b = AW'($urandom_range(0, 31));
            raddr_c = AW'($urandom_range(0, 31));
            waddr_a = AW'($urandom_range(0, 31));
            we_a = $urandom_range(0, 1);
            @(negedge clk);
            model_expect();
            checks++; if (we_b !== exp_we) begin errors++; $display("FAIL rnd_we c=%0d act=%0h exp=%0h", c, we_b, exp_we); end
            if (exp_we) begin
                checks++; if (waddr_b !== exp_waddr || wdata_b !== exp_wdata) begin errors++; $display("FAIL rnd_wb c=%0d act=%0h/%0h exp=%0h/%0h", c, waddr_b, wdata_b, exp_waddr, exp_wdata); end
            end
            checks++; if (rsp_ready !== exp_rsp_ready) begin errors++; $display("FAIL rnd_rsp_ready c=%0d act=%0h exp=%0h", c, rsp_ready, exp_rsp_ready); end
            checks++; if (issue_ready !== exp_issue_ready) begin errors++; $display("FAIL rnd_issue_ready c=%0d act=%0h exp=%0h", c, issue_ready, exp_issue_ready); end
            checks++; if (hazard !== exp_hazard) begin errors++; $display("FAIL rnd_hazard c=%0d act=%0h exp=%0h", c, hazard, exp_hazard); end
            checks++; if (pending !== exp_pending) begin errors++; $display("FAIL rnd_pending c=%0d act=%0h exp=%0h", c, pending, exp_pending); end
            checks++; if (err !== exp_err) begin errors++; $display("FAIL rnd_err c=%0d act=%0h exp=%0h", c, err, exp_err); end
            model_step();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hazard(5'd7);
        test_hazard(5'd0);
        test_reissue();
        test_back_to_back();
        test_error();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cv32e40p_rf_wb_buffer.md
# cv32e40p_rf_wb_buffer

Write-back buffer and pending-register scoreboard in front of register-file write port B. It tracks destination registers of issued long-latency operations (loads, multicycle/FP results) and buffers their responses in a small FIFO. It drains that FIFO into write port B, one entry per cycle. It also raises a hazard to the ID stage when an enabled read or port-A write targets a still-pending register.

## Interface
- ADDR_WIDTH, 5: register address width; 6 when FP registers are addressed (addresses 32–63 are FP).
- DATA_WIDTH, 32: write data width.
- DEPTH, 2: response FIFO entries, power of two, ≥2.
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- issue_valid_i  in  1  long-latency op with destination issued.
- issue_waddr_i  in  ADDR_WIDTH  destination of issued op.
- issue_ready_o  out  1  issue accepted; low if issue_waddr_i is already pending.
- rsp_valid_i  in  1  result available.
- rsp_waddr_i  in  ADDR_WIDTH  result destination.
- rsp_wdata_i  in  DATA_WIDTH  result data.
- rsp_ready_o  out  1  FIFO can accept a result.
- waddr_b_o  out  ADDR_WIDTH  to register file waddr_b_i.
- wdata_b_o  out  DATA_WIDTH  to register file wdata_b_i.
- we_b_o  out  1  to register file we_b_i.
- raddr_a_i, raddr_b_i, raddr_c_i  in  ADDR_WIDTH each  ID read addresses.
- ren_i  in  3  read enables {c,b,a}.
- waddr_a_i  in  ADDR_WIDTH  port-A write address (WAW check).
- we_a_i  in  1  port-A write enable.
- hazard_o  out  1  ID must stall.
- pending_o  out  2**ADDR_WIDTH  scoreboard bit vector.
- err_o  out  1  sticky protocol error.

## Operation
- Scoreboard: one bit per address. Bit 0 is hardwired 0, and issue or response to address 0 never sets it.
- Issue handshake: issue_ready_o = ~pending[issue_waddr_i]. On issue_valid_i & issue_ready_o with address ≠0, the bit is set at the next edge.
- Response handshake: rsp_ready_o = (count < DEPTH). On rsp_valid_i & rsp_ready_o, {waddr,wdata} is pushed at the tail.
- Drain: we_b_o = FIFO non-empty, and waddr_b_o/wdata_b_o come from the head. The head pops every cycle we_b_o is high; the register file always accepts.
- Scoreboard clear: the bit is cleared at the edge where its entry is written (we_b_o high), not on response acceptance.
- Set and clear on the same address in the same cycle cannot occur, because issue is blocked while the bit is set. Set and clear on different addresses are both applied.
- Hazard: hazard_o = OR over enabled ports of pending[raddr_x], OR (we_a_i & pending[waddr_a_i]). Address 0 never hazards.
- Error: err_o is set, and stays set until reset, when a response is accepted for an address whose pending bit is 0. Address 0 is exempt. The response is still written.
- Pointers wrap modulo DEPTH. count = 0..DEPTH. Simultaneous push and pop at full is allowed only if rsp_ready_o was high, so push at full never happens.

## Timing
- All state resets to 0 asynchronously: FIFO empty, scoreboard clear, err_o=0.
- Outputs during reset: we_b_o=0, waddr_b_o=0, wdata_b_o=0, hazard_o=0, pending_o=0, err_o=0, rsp_ready_o=1, issue_ready_o=1.
- Reset asserted mid-operation discards FIFO contents and pending bits immediately. No write reaches port B after reset asserts.
- Issue accepted in cycle N: hazard_o is visible from cycle N+1.
- Response accepted in cycle N (no bypass): we_b_o is high in cycle N+1. The register-file contents and the pending clear are visible from N+2.
- Throughput is one response per cycle sustained.

## Configuration
- CV32E40P_WB_BYPASS_EN defined: when the FIFO is empty and a response is accepted, it drives port B combinationally in the same cycle and is not pushed. Latency is 0 cycles; the pending bit clears at the next edge.
- CV32E40P_WB_BYPASS_EN undefined: every response goes through the FIFO, with 1-cycle latency. There is no combinational path from rsp_* to port B.

## Test plan
- Reset, then issue x5, then response x5=0xDEADBEEF: we_b_o is high one cycle later with waddr_b_o=5 (0 cycles with bypass). pending_o[5] is 1 from issue+1 and 0 after the write. err_o=0.
- Issue x7, then hold ren_i=3'b001 with raddr_a_i=7: hazard_o=1 until the cycle after the x7 write. The same sequence with raddr_a_i=0 gives hazard_o=0 throughout.
- Issue x3, then re-issue x3 while pending: issue_ready_o=0 and the scoreboard is unchanged. After the write-back, issue_ready_o=1.
- DEPTH=2, responses x1/x2/x3 back-to-back with a forced register of each: rsp_ready_o stays 1, in-order writes 1,2,3 on consecutive cycles, no overflow.
- Response to x9 with pending[9]=0: err_o rises and stays 1 until rst_n low, and the x9 write still occurs.
- Pending x4 and FIFO holding one entry, assert rst_n=0 mid-cycle: we_b_o drops immediately and pending_o=0. After release, FIFO empty and rsp_ready_o=1.
